nand_cmd_addr_seq: RTL and testbench

//  Per-bus NAND command/address latch sequencer (async/SDR interface). Accepts a

---
 rtl/nand_seq_pkg.sv | 44 ++++
 rtl/nand_cmd_addr_seq_latch_timer.sv | 57 +++++
 rtl/nand_cmd_addr_seq.sv | 174 +++++++++++++++++
 tb/tb_nand_cmd_addr_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_seq_pkg.sv
// Shared types and constants for the NAND command/address latch sequencer.
package nand_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CE_SETUP,
        ST_CMD0,
        ST_ADDR,
        ST_CMD1,
        ST_WB_WAIT,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_SU,
        PH_WP,
        PH_WH
    } latch_phase_t;

    // Common ONFI opcodes used by the controller core
    localparam logic [7:0] OP_RESET   = 8'hFF;
    localparam logic [7:0] OP_READ_1  = 8'h00;
    localparam logic [7:0] OP_READ_2  = 8'h30;
    localparam logic [7:0] OP_PROG_1  = 8'h80;
    localparam logic [7:0] OP_PROG_2  = 8'h10;
    localparam logic [7:0] OP_ERASE_1 = 8'h60;
    localparam logic [7:0] OP_ERASE_2 = 8'hD0;
    localparam logic [7:0] OP_STATUS  = 8'h70;

    localparam logic [2:0] MAX_ADDR_BYTES = 3'd5;

    // Largest of the timing parameters, used to size the cycle counters
    function automatic int max5(input int a, input int b, input int c,
                                input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/nand_cmd_addr_seq_latch_timer.sv
// Per-latch phase generator: walks SU -> WP -> WH while enabled and flags the
// final WH cycle so the sequencer can move to the next latch or state.
module nand_latch_timer
    import nand_seq_pkg::*;
#(
    parameter int T_SU_CYC = 1,
    parameter int T_WP_CYC = 2,
    parameter int T_WH_CYC = 2,
    parameter int CNT_W    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output latch_phase_t phase,
    output logic         last
);

    localparam logic [CNT_W-1:0] SU_END = CNT_W'(T_SU_CYC - 1);
    localparam logic [CNT_W-1:0] WP_END = CNT_W'(T_WP_CYC - 1);
    localparam logic [CNT_W-1:0] WH_END = CNT_W'(T_WH_CYC - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase_end;

    // Decode the final cycle of the current phase and of the whole latch
    always_comb begin
        phase_end = 1'b0;
        case (phase)
            PH_SU:   phase_end = (cnt == SU_END);
            PH_WP:   phase_end = (cnt == WP_END);
            PH_WH:   phase_end = (cnt == WH_END);
            default: phase_end = 1'b1;
        endcase
        last = en && (phase == PH_WH) && phase_end;
    end

    // Phase/counter register; counter reloads at every phase boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_SU;
            cnt   <= '0;
        end else if (!en) begin
            phase <= PH_SU;
            cnt   <= '0;
        end else if (phase_end) begin
            cnt <= '0;
            case (phase)
                PH_SU:   phase <= PH_WP;
                PH_WP:   phase <= PH_WH;
                default: phase <= PH_SU;
            endcase
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nand_cmd_addr_seq.sv
// NAND command/address latch sequencer: issues cmd0, up to five address bytes
// and an optional cmd1 to one chip, waits tWB, then pulses done.
module nand_cmd_addr_seq
    import nand_seq_pkg::*;
#(
    parameter int NUM_CE   = 8,
    parameter int CE_W     = 3,
    parameter int T_CS_CYC = 1,
    parameter int T_SU_CYC = 1,
    parameter int T_WP_CYC = 2,
    parameter int T_WH_CYC = 2,
    parameter int T_WB_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_cmd0,
    input  logic [2:0]        req_naddr,
    input  logic [39:0]       req_addr,
    input  logic              req_has_cmd1,
    input  logic [7:0]        req_cmd1,
    input  logic [CE_W-1:0]   req_ce,
    output logic              done,
    output logic              busy,
    output logic [NUM_CE-1:0] nand_cen,
    output logic              nand_cle,
    output logic              nand_ale,
    output logic              nand_wen,
    output logic              nand_wrn,
    output logic [7:0]        nand_dq_o,
    output logic              nand_dq_oe
);

    localparam int T_MAX = max5(T_CS_CYC, T_SU_CYC, T_WP_CYC, T_WH_CYC, T_WB_CYC);
    localparam int CNT_W = $clog2(T_MAX) + 1;
    localparam logic [CNT_W-1:0] CS_END = CNT_W'(T_CS_CYC - 1);
    localparam logic [CNT_W-1:0] WB_END = CNT_W'(T_WB_CYC - 1);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [2:0]        acnt_q, acnt_d;

    logic [7:0]        cmd0_q, cmd1_q;
    logic [2:0]        naddr_q;
    logic [39:0]       addr_q;
    logic              has_cmd1_q;
    logic [CE_W-1:0]   ce_q;

    logic [NUM_CE-1:0] ce_sel;
    logic              latch_en;
    logic              latch_last;
    latch_phase_t      latch_phase;
    seq_state_t        after_addr;

    assign ce_sel     = ~(NUM_CE'(1) << ce_q);
    assign latch_en   = (state_q == ST_CMD0) || (state_q == ST_ADDR) || (state_q == ST_CMD1);
    assign after_addr = has_cmd1_q ? ST_CMD1 : ST_WB_WAIT;
    assign nand_wrn   = 1'b1;
    assign busy       = ~req_ready;

    nand_latch_timer #(
        .T_SU_CYC (T_SU_CYC),
        .T_WP_CYC (T_WP_CYC),
        .T_WH_CYC (T_WH_CYC),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (latch_en),
        .phase (latch_phase),
        .last  (latch_last)
    );

    // State and sequencing counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            acnt_q  <= acnt_d;
        end
    end

    // Capture the request at accept; fields are ignored afterwards
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            cmd0_q     <= req_cmd0;
            cmd1_q     <= req_cmd1;
            naddr_q    <= (req_naddr > MAX_ADDR_BYTES) ? MAX_ADDR_BYTES : req_naddr;
            addr_q     <= req_addr;
            has_cmd1_q <= req_has_cmd1;
            ce_q       <= req_ce;
        end
    end

    // Next-state and pin/handshake decode
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        acnt_d     = acnt_q;
        req_ready  = 1'b0;
        done       = 1'b0;
        nand_cen   = '1;
        nand_cle   = 1'b0;
        nand_ale   = 1'b0;
        nand_wen   = 1'b1;
        nand_dq_o  = 8'h00;
        nand_dq_oe = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_CE_SETUP;
                    wcnt_d  = '0;
                end
            end
            ST_CE_SETUP: begin
                nand_cen = ce_sel;
                if (wcnt_q == CS_END) state_d = ST_CMD0;
                else                  wcnt_d  = wcnt_q + CNT_W'(1);
            end
            ST_CMD0: begin
                nand_cen   = ce_sel;
                nand_cle   = 1'b1;
                nand_dq_o  = cmd0_q;
                nand_dq_oe = 1'b1;
                nand_wen   = (latch_phase != PH_WP);
                if (latch_last) begin
                    acnt_d  = '0;
                    wcnt_d  = '0;
                    state_d = (naddr_q != 3'd0) ? ST_ADDR : after_addr;
                end
            end
            ST_ADDR: begin
                nand_cen   = ce_sel;
                nand_ale   = 1'b1;
                nand_dq_o  = addr_q[{acnt_q, 3'b000} +: 8];
                nand_dq_oe = 1'b1;
                nand_wen   = (latch_phase != PH_WP);
                if (latch_last) begin
                    wcnt_d = '0;
                    if (acnt_q + 3'd1 == naddr_q) state_d = after_addr;
                    else                          acnt_d  = acnt_q + 3'd1;
                end
            end
            ST_CMD1: begin
                nand_cen   = ce_sel;
                nand_cle   = 1'b1;
                nand_dq_o  = cmd1_q;
                nand_dq_oe = 1'b1;
                nand_wen   = (latch_phase != PH_WP);
                if (latch_last) begin
                    wcnt_d  = '0;
                    state_d = ST_WB_WAIT;
                end
            end
            ST_WB_WAIT: begin
                nand_cen = ce_sel;
                if (wcnt_q == WB_END) state_d = ST_DONE;
                else                  wcnt_d  = wcnt_q + CNT_W'(1);
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nand_cmd_addr_seq.sv
// Self-checking bench for nand_cmd_addr_seq: table vectors, corner-case
// sequences and random requests against a per-cycle waveform model.
module tb_nand_cmd_addr_seq;
    import nand_seq_pkg::*;

    localparam int NUM_CE = 8;
    localparam int CE_W   = 3;
    localparam int T_CS   = 1;
    localparam int T_SU   = 1;
    localparam int T_WP   = 2;
    localparam int T_WH   = 2;
    localparam int T_WB   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [7:0]        req_cmd0 = 8'h00;
    logic [2:0]        req_naddr = 3'd0;
    logic [39:0]       req_addr = 40'h0;
    logic              req_has_cmd1 = 1'b0;
    logic [7:0]        req_cmd1 = 8'h00;
    logic [CE_W-1:0]   req_ce = '0;
    logic              done;
    logic              busy;
    logic [NUM_CE-1:0] nand_cen;
    logic              nand_cle;
    logic              nand_ale;
    logic              nand_wen;
    logic              nand_wrn;
    logic [7:0]        nand_dq_o;
    logic              nand_dq_oe;

    always #5 clk = ~clk;

    nand_cmd_addr_seq #(
        .NUM_CE(NUM_CE), .CE_W(CE_W), .T_CS_CYC(T_CS), .T_SU_CYC(T_SU),
        .T_WP_CYC(T_WP), .T_WH_CYC(T_WH), .T_WB_CYC(T_WB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd0(req_cmd0), .req_naddr(req_naddr), .req_addr(req_addr),
        .req_has_cmd1(req_has_cmd1), .req_cmd1(req_cmd1), .req_ce(req_ce),
        .done(done), .busy(busy), .nand_cen(nand_cen), .nand_cle(nand_cle),
        .nand_ale(nand_ale), .nand_wen(nand_wen), .nand_wrn(nand_wrn),
        .nand_dq_o(nand_dq_o), .nand_dq_oe(nand_dq_oe)
    );

    typedef struct packed {
        logic [7:0] cen;
        logic       cle;
        logic       ale;
        logic       wen;
        logic [7:0] dq;
        logic       oe;
        logic       done;
        logic       ready;
    } obs_t;

    typedef struct {
        logic [7:0]  cmd0;
        logic [2:0]  naddr;
        logic [39:0] addr;
        logic        has1;
        logic [7:0]  cmd1;
        logic [2:0]  ce;
    } req_t;

    typedef struct {
        req_t r;
        int   exp_done;
        int   exp_ale;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    obs_t idle_obs;

    function automatic obs_t mk(logic [7:0] cen, logic cle, logic ale, logic wen,
                                logic [7:0] dq, logic oe, logic dn, logic rdy);
        obs_t o;
        o.cen = cen; o.cle = cle; o.ale = ale; o.wen = wen;
        o.dq = dq; o.oe = oe; o.done = dn; o.ready = rdy;
        return o;
    endfunction

    // One latch: SU, WP (WE# low), WH, all with the byte on DQ
    function automatic void push_latch(logic [7:0] cen_on, logic is_cmd, logic [7:0] b);
        for (int i = 0; i < T_SU; i++) exp_q.push_back(mk(cen_on, is_cmd, !is_cmd, 1'b1, b, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < T_WP; i++) exp_q.push_back(mk(cen_on, is_cmd, !is_cmd, 1'b0, b, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < T_WH; i++) exp_q.push_back(mk(cen_on, is_cmd, !is_cmd, 1'b1, b, 1'b1, 1'b0, 1'b0));
    endfunction

    // Expected pins for every cycle after accept, up to and including DONE
    function automatic void model(req_t r);
        logic [7:0]  cen_on;
        int          n;
        logic [39:0] a;
        cen_on = 8'hFF;
        cen_on[r.ce] = 1'b0;
        n = (r.naddr > 3'd5) ? 5 : int'(r.naddr);
        a = r.addr;
        for (int i = 0; i < T_CS; i++) exp_q.push_back(mk(cen_on, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
        push_latch(cen_on, 1'b1, r.cmd0);
        for (int k = 0; k < n; k++) begin
            push_latch(cen_on, 1'b0, a[7:0]);
            a = a >> 8;
        end
        if (r.has1) push_latch(cen_on, 1'b1, r.cmd1);
        for (int i = 0; i < T_WB; i++) exp_q.push_back(mk(cen_on, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0));
    endfunction

    function automatic obs_t sample();
        return mk(nand_cen, nand_cle, nand_ale, nand_wen, nand_dq_o, nand_dq_oe, done, req_ready);
    endfunction

    task automatic check_obs(string name, obs_t act, obs_t exp);
        checks++;
        if (!exp.oe) begin
            act.dq = 8'h00;
            exp.dq = 8'h00;
        end
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cen/cle/ale/wen/dq/oe/done/ready)", name, act, exp);
        end
    endtask

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_inv();
        logic ok;
        ok = 1'b1;
        checks++;
        if (nand_wrn !== 1'b1) ok = 1'b0;
        if (nand_cle && nand_ale) ok = 1'b0;
        if ($countones(~nand_cen) > 1) ok = 1'b0;
        if (!nand_wen && !((nand_cle ^ nand_ale) && nand_dq_oe && ($countones(~nand_cen) == 1))) ok = 1'b0;
        if (busy !== ~req_ready) ok = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL invariants @%0t: cen=%b cle=%b ale=%b wen=%b wrn=%b oe=%b busy=%b ready=%b",
                     $time, nand_cen, nand_cle, nand_ale, nand_wen, nand_wrn, nand_dq_oe, busy, req_ready);
        end
    endtask

    task automatic set_req(req_t r);
        req_cmd0 = r.cmd0; req_naddr = r.naddr; req_addr = r.addr;
        req_has_cmd1 = r.has1; req_cmd1 = r.cmd1; req_ce = r.ce;
    endtask

    // Compare each queued cycle; drop req_valid and scramble fields at drop_idx
    task automatic check_stream(string name, int drop_idx, output int done_cyc, output int ale_cnt);
        obs_t a;
        logic prev_wen;
        int   n;
        n = exp_q.size();
        prev_wen = 1'b1;
        done_cyc = -1;
        ale_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            a = sample();
            check_obs(name, a, exp_q[k]);
            check_inv();
            if (a.done && done_cyc < 0) done_cyc = k + 1;
            if (a.ale && !a.wen && prev_wen) ale_cnt++;
            prev_wen = a.wen;
            if (k == drop_idx) begin
                req_valid = 1'b0;
                req_cmd0 = 8'($urandom); req_naddr = 3'($urandom); req_addr = {8'($urandom), $urandom};
                req_has_cmd1 = 1'($urandom); req_cmd1 = 8'($urandom); req_ce = 3'($urandom);
            end
        end
        exp_q.delete();
    endtask

    task automatic run_txn(string name, req_t r, output int done_cyc, output int ale_cnt);
        @(negedge clk);
        check_val({name, "_ready"}, int'(req_ready), 1);
        set_req(r);
        req_valid = 1'b1;
        model(r);
        exp_q.push_back(idle_obs);
        @(posedge clk);
        check_stream(name, 0, done_cyc, ale_cnt);
    endtask

    vec_t tbl[6];
    req_t ra, rb, rr;
    int   dc, ac, len_a;

    initial begin
        idle_obs = mk(8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[0] = '{'{OP_RESET,   3'd0, 40'h0,            1'b0, 8'h00,      3'd2}, 11, 0};
        tbl[1] = '{'{OP_READ_1,  3'd5, 40'h04_0302_0100, 1'b1, OP_READ_2,  3'd0}, 41, 5};
        tbl[2] = '{'{OP_ERASE_1, 3'd7, 40'hA5_5AC3_3C99, 1'b1, OP_ERASE_2, 3'd5}, 41, 5};
        tbl[3] = '{'{OP_STATUS,  3'd0, 40'h0,            1'b0, 8'h00,      3'd7}, 11, 0};
        tbl[4] = '{'{OP_PROG_1,  3'd5, 40'h11_2233_4455, 1'b0, OP_PROG_2,  3'd3}, 36, 5};
        tbl[5] = '{'{OP_ERASE_1, 3'd3, 40'h00_00CC_BBAA, 1'b1, OP_ERASE_2, 3'd6}, 31, 3};

        // Reset values, observed without any clock edge
        #1 rst_n = 1'b0;
        #2;
        check_obs("reset_pins", sample(), idle_obs);
        check_val("reset_dq", int'(nand_dq_o), 0);
        check_val("reset_wrn", int'(nand_wrn), 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].r, dc, ac);
            check_val($sformatf("vec%0d_done_cycle", i), dc, tbl[i].exp_done);
            check_val($sformatf("vec%0d_ale_latches", i), ac, tbl[i].exp_ale);
        end

        // Back-to-back: B held valid while A runs, accepted the cycle after A's done
        ra = tbl[0].r;
        rb = tbl[3].r;
        @(negedge clk);
        set_req(ra);
        req_valid = 1'b1;
        model(ra);
        len_a = exp_q.size();
        exp_q.push_back(idle_obs);
        model(rb);
        exp_q.push_back(idle_obs);
        @(posedge clk);
        #1 set_req(rb);
        check_stream("b2b", len_a + 1, dc, ac);
        check_val("b2b_first_done", dc, 11);

        // Reset asserted mid-ADDR at cycle 15, between clock edges
        rr = tbl[1].r;
        @(negedge clk);
        set_req(rr);
        req_valid = 1'b1;
        model(rr);
        exp_q = exp_q[0:14];
        @(posedge clk);
        check_stream("pre_reset", 0, dc, ac);
        check_val("pre_reset_in_addr", int'(nand_ale), 1);
        #2 rst_n = 1'b0;
        #1;
        check_obs("async_reset_pins", sample(), idle_obs);
        check_val("async_reset_dq", int'(nand_dq_o), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_txn("after_reset", tbl[0].r, dc, ac);
        check_val("after_reset_done_cycle", dc, 11);

        // Random requests with idle gaps
        for (int t = 0; t < 25; t++) begin
            rr.cmd0  = 8'($urandom);
            rr.naddr = 3'($urandom_range(0, 7));
            rr.addr  = {8'($urandom), $urandom};
            rr.has1  = 1'($urandom);
            rr.cmd1  = 8'($urandom);
            rr.ce    = 3'($urandom_range(0, 7));
            run_txn($sformatf("rand%0d", t), rr, dc, ac);
            check_val($sformatf("rand%0d_ale", t), ac, (rr.naddr > 3'd5) ? 5 : int'(rr.naddr));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
